// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter/interval timer with terminal-count pulse
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, stop     arm with load_val/auto_reload, or abort to IDLE (stop wins)
//   load_val        start value, captured with start
//   auto_reload     1 = periodic, 0 = one-shot, captured with start
//   en              count enable, effective only in RUN
//   count           registered counter value
//   tc              one-cycle terminal-count pulse
//   busy, done      state RUN / state DONE
module down_counter_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] reload_val, reload_n, count_n;
   logic             mode, mode_n, tc_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_val <= '0;
         mode       <= 1'b0;
         tc         <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload_val <= reload_n;
         mode       <= mode_n;
         tc         <= tc_n;
      end
   end
   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload_val;
      mode_n   = mode;
      tc_n     = 1'b0;
      if (stop) begin
         state_n = IDLE;
         count_n = '0;
      end else if (start) begin
         reload_n = load_val;
         mode_n   = auto_reload;
         count_n  = load_val;
         tc_n     = (load_val == '0);
         state_n  = (load_val == '0 && !auto_reload) ? DONE : RUN;
      end else if (state == RUN && en) begin
         if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
         end else if (count == WIDTH'(1)) begin
            count_n = '0;
            tc_n    = 1'b1;
            state_n = mode ? RUN : DONE;
         end else begin
            // Periodic reload from zero; a zero reload value re-fires tc on alternate edges
            count_n = reload_val;
            tc_n    = (reload_val == '0) && !tc;
         end
      end
   end
   assign busy = (state == RUN);
   assign done = (state == DONE);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: table-driven self-checking bench for down_counter_timer
module tb_down_counter_timer;
   typedef struct {
      logic       rst, start, stop, al, en;
      logic [2:0] lv;
      logic [2:0] cnt;
      logic       tc, busy, done;
   } vec_t;

   logic       clk = 1'b0, rst, start, stop, auto_reload, en;
   logic [2:0] load_val, count;
   logic       tc, busy, done;
   int         checks = 0, failures = 0;
   vec_t       vecs[$];

   down_counter_timer #(.WIDTH(3)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .load_val(load_val),
      .auto_reload(auto_reload), .en(en), .count(count), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int r, s, p, a, e, lv, c, t, b, d);
      vec_t v;
      v.rst = r[0]; v.start = s[0]; v.stop = p[0]; v.al = a[0]; v.en = e[0];
      v.lv = lv[2:0]; v.cnt = c[2:0]; v.tc = t[0]; v.busy = b[0]; v.done = d[0];
      return v;
   endfunction

   task automatic chk(input string tag, input int idx, input string sig, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s[%0d] %s got=%0d exp=%0d", tag, idx, sig, got, exp);
      end
   endtask

   task automatic apply(input string tag, input int idx, input vec_t v);
      rst = v.rst; start = v.start; stop = v.stop; auto_reload = v.al; en = v.en; load_val = v.lv;
      @(posedge clk);
      #1;
      chk(tag, idx, "count", int'(count), int'(v.cnt));
      chk(tag, idx, "tc", int'(tc), int'(v.tc));
      chk(tag, idx, "busy", int'(busy), int'(v.busy));
      chk(tag, idx, "done", int'(done), int'(v.done));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; en = 1'b0; load_val = '0;
      //              rst st sp al en lv  cnt tc b  d
      vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0)); // reset
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0)); // en ignored in IDLE
      vecs.push_back(mk(0, 1, 0, 0, 1, 5,  5, 0, 1, 0)); // one-shot load 5
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  4, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 0, 1)); // tc + done, busy drops
      vecs.push_back(mk(0, 1, 0, 0, 1, 5,  5, 0, 1, 0)); // restart from DONE
      vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0, 0, 0)); // reset mid-count at 5
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 3,  3, 0, 1, 0)); // periodic load 3
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0)); // reload
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 6,  6, 0, 1, 0)); // restart at 2, decrement discarded
      vecs.push_back(mk(0, 1, 1, 0, 1, 4,  0, 0, 0, 0)); // stop beats start
      vecs.push_back(mk(0, 1, 0, 0, 1, 7,  7, 0, 1, 0)); // max load one-shot
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  6, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  5, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  4, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 1)); // no underflow
      vecs.push_back(mk(0, 1, 0, 0, 1, 0,  0, 1, 0, 1)); // load 0 one-shot
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0,  0, 0, 0, 0)); // stop from DONE
      vecs.push_back(mk(0, 1, 0, 1, 1, 0,  0, 1, 1, 0)); // periodic load 0
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
      foreach (vecs[i]) apply("vec", i, vecs[i]);

      // one-shot: count stays 0 in DONE for 10 enabled cycles
      apply("os", 0, mk(0, 1, 0, 0, 1, 2, 2, 0, 1, 0));
      apply("os", 1, mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
      apply("os", 2, mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
      for (int i = 0; i < 10; i++) apply("os_hold", i, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

      // enable gating at count 1
      apply("gate", 0, mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 0));
      for (int i = 0; i < 5; i++) apply("gate_hold", i, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      apply("gate", 1, mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
